// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for an 8-bit combinational ALU: a debounced STEP button walks
// load A -> load B -> load OP -> execute -> show, capturing the ALU result and flags.
module alu_operand_sequencer #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             CLK,
  input  logic             RST_L,
  input  logic [WIDTH-1:0] DIN,
  input  logic [2:0]       OP_IN,
  input  logic             STEP_L,
  input  logic             CLEAR_L,
  input  logic [WIDTH-1:0] Y_IN,
  input  logic [3:0]       FLAGS_IN,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       OP,
  output logic [WIDTH-1:0] RESULT,
  output logic [3:0]       FLAGS,
  output logic [2:0]       STATE,
  output logic             VALID
);

  typedef enum logic [2:0] {
    StLoadA  = 3'd0,
    StLoadB  = 3'd1,
    StLoadOp = 3'd2,
    StExec   = 3'd3,
    StShow   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             step_meta, s_step;
  logic             clr_meta, s_clr;
  logic             deb_q, deb_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       warm_q;
  logic             armed_q;
  logic             press_q;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [2:0]       op_q;
  logic [3:0]       flags_q;
  logic             valid_q;

  // Two-flop synchronizers, preset to the released level.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      step_meta <= 1'b1;
      s_step    <= 1'b1;
      clr_meta  <= 1'b1;
      s_clr     <= 1'b1;
    end else begin
      step_meta <= STEP_L;
      s_step    <= step_meta;
      clr_meta  <= CLEAR_L;
      s_clr     <= clr_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else if (s_step == deb_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      deb_q <= s_step;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Presses are only accepted once a genuine released level has been seen after reset,
  // so a button held down across reset release cannot step the sequencer.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      warm_q    <= 2'b00;
      armed_q   <= 1'b0;
      deb_dly_q <= 1'b1;
      press_q   <= 1'b0;
    end else begin
      warm_q    <= {warm_q[0], 1'b1};
      armed_q   <= armed_q | (warm_q[1] & s_step);
      deb_dly_q <= deb_q;
      press_q   <= armed_q & deb_dly_q & ~deb_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q  <= StLoadA;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else if (!s_clr) begin
      state_q  <= StLoadA;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        StLoadA: begin
          if (press_q) begin
            a_q     <= DIN;
            valid_q <= 1'b0;
            state_q <= StLoadB;
          end
        end
        StLoadB: begin
          if (press_q) begin
            b_q     <= DIN;
            state_q <= StLoadOp;
          end
        end
        StLoadOp: begin
          if (press_q) begin
            op_q    <= OP_IN;
            state_q <= StExec;
          end
        end
        StExec: begin
          result_q <= Y_IN;
          flags_q  <= FLAGS_IN;
          valid_q  <= 1'b1;
          state_q  <= StShow;
        end
        StShow: begin
          if (press_q) state_q <= StLoadA;
        end
        default: state_q <= StLoadA;
      endcase
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign OP     = op_q;
  assign RESULT = result_q;
  assign FLAGS  = flags_q;
  assign STATE  = state_q;
  assign VALID  = valid_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a 4-cycle debounce and an adder ALU model.
module tb_alu_operand_sequencer;

  logic       CLK = 1'b0;
  logic       RST_L;
  logic [7:0] DIN;
  logic [2:0] OP_IN;
  logic       STEP_L;
  logic       CLEAR_L;
  logic [7:0] Y_IN;
  logic [3:0] FLAGS_IN;
  logic [7:0] A, B, RESULT;
  logic [2:0] OP, STATE;
  logic [3:0] FLAGS;
  logic       VALID;
  logic [8:0] sum;

  int checks = 0;
  int errors = 0;

  alu_operand_sequencer #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20)
  ) dut (
    .CLK(CLK),
    .RST_L(RST_L),
    .DIN(DIN),
    .OP_IN(OP_IN),
    .STEP_L(STEP_L),
    .CLEAR_L(CLEAR_L),
    .Y_IN(Y_IN),
    .FLAGS_IN(FLAGS_IN),
    .A(A),
    .B(B),
    .OP(OP),
    .RESULT(RESULT),
    .FLAGS(FLAGS),
    .STATE(STATE),
    .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  // Adder ALU model: flags {C,V,N,Z}.
  always_comb begin
    sum      = {1'b0, A} + {1'b0, B};
    Y_IN     = sum[7:0];
    FLAGS_IN = {sum[8], (A[7] == B[7]) && (sum[7] != A[7]), sum[7], sum[7:0] == 8'h00};
  end

  // Press lands at edge 7 after the fall, the FSM acts on edge 8.
  task automatic fall_wait();
    @(negedge CLK) STEP_L = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
  endtask

  task automatic release_wait();
    @(negedge CLK) STEP_L = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
  endtask

  task automatic step_press(input logic [7:0] din_v, input logic [2:0] op_v);
    DIN   = din_v;
    OP_IN = op_v;
    fall_wait();
    release_wait();
  endtask

  task automatic test_reset;
    RST_L = 1'b0; STEP_L = 1'b1; CLEAR_L = 1'b1; DIN = 8'h00; OP_IN = 3'd0;
    #1;
    checks++; if ({A, B, OP, RESULT, FLAGS, VALID} !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {A, B, OP, RESULT, FLAGS, VALID});
    end
    checks++; if (STATE !== 3'd0) begin
      errors++; $display("FAIL reset_state got %0d want 0", STATE);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST_L = 1'b1;
    repeat (5) @(posedge CLK);
  endtask

  task automatic test_full_sequence;
    DIN = 8'h3C;
    fall_wait();
    checks++; if (STATE !== 3'd1 || A !== 8'h3C || VALID !== 1'b0) begin
      errors++; $display("FAIL load_a got st=%0d a=%h v=%b want 1 3c 0", STATE, A, VALID);
    end
    release_wait();
    DIN = 8'h05;
    fall_wait();
    checks++; if (STATE !== 3'd2 || B !== 8'h05) begin
      errors++; $display("FAIL load_b got st=%0d b=%h want 2 05", STATE, B);
    end
    release_wait();
    OP_IN = 3'b000;
    fall_wait();
    checks++; if (STATE !== 3'd3 || OP !== 3'd0 || VALID !== 1'b0) begin
      errors++; $display("FAIL load_op got st=%0d op=%0d v=%b want 3 0 0", STATE, OP, VALID);
    end
    @(posedge CLK); #1;
    checks++; if (STATE !== 3'd4 || RESULT !== 8'h41 || FLAGS !== 4'b0000 || VALID !== 1'b1) begin
      errors++; $display("FAIL exec_add got st=%0d r=%h f=%b v=%b want 4 41 0000 1",
                         STATE, RESULT, FLAGS, VALID);
    end
    release_wait();
    checks++; if (STATE !== 3'd4 || A !== 8'h3C || B !== 8'h05) begin
      errors++; $display("FAIL show_hold got st=%0d a=%h b=%h want 4 3c 05", STATE, A, B);
    end
  endtask

  task automatic test_overflow;
    step_press(8'h00, 3'd0);
    checks++; if (STATE !== 3'd0 || VALID !== 1'b1 || RESULT !== 8'h41) begin
      errors++; $display("FAIL show_to_a got st=%0d v=%b r=%h want 0 1 41", STATE, VALID, RESULT);
    end
    step_press(8'h7F, 3'd0);
    checks++; if (VALID !== 1'b0 || A !== 8'h7F) begin
      errors++; $display("FAIL ovf_load_a got v=%b a=%h want 0 7f", VALID, A);
    end
    step_press(8'h01, 3'd0);
    DIN = 8'h99; OP_IN = 3'b001;
    fall_wait();
    @(posedge CLK); #1;
    checks++; if (STATE !== 3'd4 || RESULT !== 8'h80 || FLAGS !== 4'b0110 || OP !== 3'b001) begin
      errors++; $display("FAIL ovf_capture got st=%0d r=%h f=%b op=%0d want 4 80 0110 1",
                         STATE, RESULT, FLAGS, OP);
    end
    release_wait();
    DIN = 8'hFF;
    repeat (5) @(posedge CLK); #1;
    checks++; if (RESULT !== 8'h80 || A !== 8'h7F || B !== 8'h01) begin
      errors++; $display("FAIL ovf_hold got r=%h a=%h b=%h want 80 7f 01", RESULT, A, B);
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK) STEP_L = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK) STEP_L = 1'b1;
      repeat (3) @(posedge CLK);
    end
    repeat (6) @(posedge CLK); #1;
    checks++; if (STATE !== 3'd4) begin
      errors++; $display("FAIL bounce_reject got st=%0d want 4", STATE);
    end
    @(negedge CLK) STEP_L = 1'b0;
    repeat (7) @(posedge CLK); #1;
    checks++; if (STATE !== 3'd4) begin
      errors++; $display("FAIL press_early got st=%0d want 4", STATE);
    end
    @(posedge CLK); #1;
    checks++; if (STATE !== 3'd0) begin
      errors++; $display("FAIL press_latency got st=%0d want 0", STATE);
    end
    repeat (4) @(posedge CLK);
    release_wait();
    checks++; if (STATE !== 3'd0 || A !== 8'h7F) begin
      errors++; $display("FAIL single_press got st=%0d a=%h want 0 7f", STATE, A);
    end
  endtask

  task automatic test_clear_priority;
    step_press(8'h11, 3'd0);
    step_press(8'h22, 3'd0);
    OP_IN = 3'd5;
    @(negedge CLK) STEP_L = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK) CLEAR_L = 1'b0;
    @(posedge CLK);
    @(negedge CLK) CLEAR_L = 1'b1;
    repeat (2) @(posedge CLK); #1;
    checks++; if (STATE !== 3'd0 || A !== 8'h00 || B !== 8'h00 || OP !== 3'd0) begin
      errors++; $display("FAIL clear_regs got st=%0d a=%h b=%h op=%0d want 0 0 0 0",
                         STATE, A, B, OP);
    end
    checks++; if (VALID !== 1'b0 || RESULT !== 8'h00 || FLAGS !== 4'h0) begin
      errors++; $display("FAIL clear_result got v=%b r=%h f=%b want 0 00 0000", VALID, RESULT, FLAGS);
    end
    release_wait();
    checks++; if (STATE !== 3'd0) begin
      errors++; $display("FAIL clear_drop got st=%0d want 0", STATE);
    end
  endtask

  task automatic test_wrap;
    step_press(8'h10, 3'd0);
    step_press(8'h20, 3'd0);
    step_press(8'h00, 3'd2);
    checks++; if (STATE !== 3'd4 || RESULT !== 8'h30) begin
      errors++; $display("FAIL wrap_exec got st=%0d r=%h want 4 30", STATE, RESULT);
    end
    step_press(8'h00, 3'd0);
    checks++; if (STATE !== 3'd0 || RESULT !== 8'h30 || VALID !== 1'b1) begin
      errors++; $display("FAIL wrap_show got st=%0d r=%h v=%b want 0 30 1", STATE, RESULT, VALID);
    end
    step_press(8'hAA, 3'd0);
    checks++; if (STATE !== 3'd1 || A !== 8'hAA || VALID !== 1'b0 || RESULT !== 8'h30) begin
      errors++; $display("FAIL wrap_load got st=%0d a=%h v=%b r=%h want 1 aa 0 30",
                         STATE, A, VALID, RESULT);
    end
  endtask

  task automatic test_reset_mid_exec;
    step_press(8'h01, 3'd0);
    step_press(8'h00, 3'd0);
    step_press(8'h00, 3'd0);
    step_press(8'h12, 3'd0);
    step_press(8'h34, 3'd0);
    OP_IN = 3'd6;
    fall_wait();
    checks++; if (STATE !== 3'd3 || A !== 8'h12) begin
      errors++; $display("FAIL pre_reset got st=%0d a=%h want 3 12", STATE, A);
    end
    #1 RST_L = 1'b0;
    #1;
    checks++; if ({A, B, OP, RESULT, FLAGS, VALID} !== 32'h0 || STATE !== 3'd0) begin
      errors++; $display("FAIL async_reset got %h st=%0d want 0 0",
                         {A, B, OP, RESULT, FLAGS, VALID}, STATE);
    end
    @(negedge CLK) RST_L = 1'b1;
    repeat (20) @(posedge CLK); #1;
    checks++; if (STATE !== 3'd0 || A !== 8'h00) begin
      errors++; $display("FAIL held_step got st=%0d a=%h want 0 00", STATE, A);
    end
    release_wait();
    DIN = 8'h5A;
    fall_wait();
    checks++; if (STATE !== 3'd1 || A !== 8'h5A) begin
      errors++; $display("FAIL post_reset_press got st=%0d a=%h want 1 5a", STATE, A);
    end
    release_wait();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout after 1ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_sequence();
    test_overflow();
    test_bounce();
    test_clear_priority();
    test_wrap();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
